// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: FS->DS pipeline register, operand forwarding with
// load-use stall, and branch cancel. Define ID_STALL_CNT_EN to add the stall-cycle counter.
module id_issue_ctrl #(
  parameter int BUS_W   = 128,
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NUM_FWD = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fs_to_ds_valid,
  input  logic [BUS_W-1:0]      fs_to_ds_bus,
  output logic                  ds_allow_in,
  input  logic                  es_allow_in,
  output logic                  ds_to_es_valid,
  output logic [BUS_W-1:0]      ds_bus,
  input  logic [AW-1:0]         rs1_addr,
  input  logic [AW-1:0]         rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [DW-1:0]         rf_rdata1,
  input  logic [DW-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]    fwd_we,
  input  logic [NUM_FWD*AW-1:0] fwd_dest,
  input  logic [NUM_FWD*DW-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]    fwd_ready,
  output logic [DW-1:0]         src1_data,
  output logic [DW-1:0]         src2_data,
  input  logic                  br_taken,
  output logic                  br_cancel,
  input  logic                  flush,
  output logic [31:0]           stall_cnt
);

  logic             ds_valid_reg;
  logic             ds_valid_next;
  logic [BUS_W-1:0] ds_bus_reg;
  logic [NUM_FWD-1:0] hit1;
  logic [NUM_FWD-1:0] hit2;
  logic             wait1;
  logic             wait2;
  logic             stall;
  logic             ds_ready_go;

  generate
    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_hit
      logic [AW-1:0] dest;
      assign dest     = fwd_dest[gi*AW +: AW];
      assign hit1[gi] = rs1_used & fwd_we[gi] & (dest != '0) & (dest == rs1_addr);
      assign hit2[gi] = rs2_used & fwd_we[gi] & (dest != '0) & (dest == rs2_addr);
    end
  endgenerate

  // Walk oldest to youngest so the youngest hit overwrites; only the winner's ready matters.
  always_comb begin
    src1_data = rf_rdata1;
    wait1     = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (hit1[k]) begin
        src1_data = fwd_data[k*DW +: DW];
        wait1     = ~fwd_ready[k];
      end
    end
  end

  always_comb begin
    src2_data = rf_rdata2;
    wait2     = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (hit2[k]) begin
        src2_data = fwd_data[k*DW +: DW];
        wait2     = ~fwd_ready[k];
      end
    end
  end

  assign stall          = ds_valid_reg & (wait1 | wait2);
  assign ds_ready_go    = ~stall;
  assign ds_to_es_valid = ds_valid_reg & ds_ready_go;
  assign ds_allow_in    = ~ds_valid_reg | (ds_ready_go & es_allow_in);
  assign br_cancel      = ds_valid_reg & ds_ready_go & es_allow_in & br_taken;
  assign ds_bus         = ds_bus_reg;

  // A taken branch drops whatever IF presents in the same cycle (wrong path).
  always_comb begin
    ds_valid_next = ds_valid_reg;
    if (flush)
      ds_valid_next = 1'b0;
    else if (br_cancel)
      ds_valid_next = 1'b0;
    else if (ds_allow_in)
      ds_valid_next = fs_to_ds_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid_reg <= 1'b0;
      ds_bus_reg   <= '0;
    end else begin
      ds_valid_reg <= ds_valid_next;
      if (fs_to_ds_valid & ds_allow_in)
        ds_bus_reg <= fs_to_ds_bus;
    end
  end

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt_reg <= '0;
    else if (stall)
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Scoreboard bench for id_issue_ctrl: stimulus queues expected issues, a negedge monitor
// pops and compares every issued instruction; per-cycle handshake state is checked inline.
module tb_id_issue_ctrl;
  localparam int BUS_W = 128;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NF = 3;
  localparam logic [DW-1:0] RF1 = 32'hA1A1_0001;
  localparam logic [DW-1:0] RF2 = 32'hB2B2_0002;

  logic clk = 1'b0;
  logic reset;
  logic fs_to_ds_valid;
  logic [BUS_W-1:0] fs_to_ds_bus;
  logic ds_allow_in;
  logic es_allow_in;
  logic ds_to_es_valid;
  logic [BUS_W-1:0] ds_bus;
  logic [AW-1:0] rs1_addr, rs2_addr;
  logic rs1_used, rs2_used;
  logic [DW-1:0] rf_rdata1, rf_rdata2;
  logic [NF-1:0] fwd_we;
  logic [NF*AW-1:0] fwd_dest;
  logic [NF*DW-1:0] fwd_data;
  logic [NF-1:0] fwd_ready;
  logic [DW-1:0] src1_data, src2_data;
  logic br_taken;
  logic br_cancel;
  logic flush;
  logic [31:0] stall_cnt;

  typedef struct {
    logic [BUS_W-1:0] bus;
    logic [DW-1:0]    s1;
    logic [DW-1:0]    s2;
    logic             bc;
    string            name;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;

  id_issue_ctrl #(.BUS_W(BUS_W), .DW(DW), .AW(AW), .NUM_FWD(NF)) dut (
    .clk(clk), .reset(reset),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .ds_allow_in(ds_allow_in), .es_allow_in(es_allow_in),
    .ds_to_es_valid(ds_to_es_valid), .ds_bus(ds_bus),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_we(fwd_we), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_ready(fwd_ready),
    .src1_data(src1_data), .src2_data(src2_data),
    .br_taken(br_taken), .br_cancel(br_cancel),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [BUS_W-1:0] act,
                                input logic [BUS_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every issue (valid & accepted by EX) must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && ds_to_es_valid && es_allow_in) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_issue: got bus %0h, expected no issue", ds_bus);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_bus"}, ds_bus, e.bus);
        check({e.name, "_src1"}, BUS_W'(src1_data), BUS_W'(e.s1));
        check({e.name, "_src2"}, BUS_W'(src2_data), BUS_W'(e.s2));
        check({e.name, "_br_cancel"}, BUS_W'(br_cancel), BUS_W'(e.bc));
        $display("[TB] issue %s bus=%0h src1=%0h src2=%0h br_cancel=%0b",
                 e.name, ds_bus, src1_data, src2_data, br_cancel);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int k, input logic we, input logic [AW-1:0] dest,
                         input logic [DW-1:0] data, input logic rdy);
    fwd_we[k]            = we;
    fwd_dest[k*AW +: AW] = dest;
    fwd_data[k*DW +: DW] = data;
    fwd_ready[k]         = rdy;
  endtask

  task automatic idle_inputs();
    fs_to_ds_valid = 1'b0;
    es_allow_in    = 1'b0;
    rs1_used = 1'b0; rs2_used = 1'b0;
    rs1_addr = '0;   rs2_addr = '0;
    fwd_we = '0; fwd_dest = '0; fwd_data = '0; fwd_ready = '0;
    br_taken = 1'b0;
    flush    = 1'b0;
  endtask

  // Load one instruction into an empty DS while EX is blocked.
  task automatic load(input logic [BUS_W-1:0] bus);
    es_allow_in    = 1'b0;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = bus;
    step();
    fs_to_ds_valid = 1'b0;
  endtask

  task automatic push(input logic [BUS_W-1:0] bus, input logic [DW-1:0] s1,
                      input logic [DW-1:0] s2, input logic bc, input string name);
    exp_t e;
    e.bus = bus; e.s1 = s1; e.s2 = s2; e.bc = bc; e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    logic [BUS_W-1:0] ba, bb, bc, bd, be, bf, bg;
    ba = {4{32'hAAAA_0001}};
    bb = {4{32'hBBBB_0002}};
    bc = {4{32'hCCCC_0003}};
    bd = {4{32'hDDDD_0004}};
    be = {4{32'hEEEE_0005}};
    bf = {4{32'hF0F0_0006}};
    bg = {4{32'h1234_0007}};
    rf_rdata1 = RF1;
    rf_rdata2 = RF2;
    fs_to_ds_bus = '0;
    idle_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    @(negedge clk);
    check("reset_ds_to_es_valid", BUS_W'(ds_to_es_valid), '0);
    check("reset_ds_allow_in", BUS_W'(ds_allow_in), BUS_W'(1));
    check("reset_br_cancel", BUS_W'(br_cancel), '0);
    check("reset_ds_bus", ds_bus, '0);
    check("reset_stall_cnt", BUS_W'(stall_cnt), '0);
    step();

    // Youngest hit wins over an older hit on the same register.
    load(ba);
    @(negedge clk);
    check("hold_ds_allow_in", BUS_W'(ds_allow_in), '0);
    step();
    rs1_addr = 5'd5; rs1_used = 1'b1;
    set_fwd(0, 1'b1, 5'd5, 32'h11, 1'b1);
    set_fwd(2, 1'b1, 5'd5, 32'h33, 1'b1);
    push(ba, 32'h11, RF2, 1'b0, "fwd_youngest");
    es_allow_in = 1'b1;
    @(negedge clk);
    check("fwd_youngest_valid", BUS_W'(ds_to_es_valid), BUS_W'(1));
    step();
    idle_inputs();

    // Middle source wins; an older non-ready hit is ignored.
    load(bg);
    rs1_addr = 5'd9; rs1_used = 1'b1;
    rs2_addr = 5'd9; rs2_used = 1'b1;
    set_fwd(0, 1'b1, 5'd3, 32'h10, 1'b1);
    set_fwd(1, 1'b1, 5'd9, 32'h22, 1'b1);
    set_fwd(2, 1'b1, 5'd9, 32'h33, 1'b0);
    push(bg, 32'h22, 32'h22, 1'b0, "fwd_middle");
    es_allow_in = 1'b1;
    step();
    idle_inputs();

    // Load-use stall on rs2, issue when producer becomes ready.
    load(bb);
    rs2_addr = 5'd7; rs2_used = 1'b1;
    set_fwd(0, 1'b1, 5'd7, 32'h0, 1'b0);
    es_allow_in = 1'b1;
    push(bb, RF1, 32'hAB, 1'b0, "stall_release");
    @(negedge clk);
    check("stall_ds_to_es_valid", BUS_W'(ds_to_es_valid), '0);
    check("stall_ds_allow_in", BUS_W'(ds_allow_in), '0);
    check("stall_ds_bus", ds_bus, bb);
    step();
    set_fwd(0, 1'b1, 5'd7, 32'hAB, 1'b1);
    step();
    idle_inputs();

    // Register zero is never forwarded.
    load(bc);
    rs1_addr = 5'd0; rs1_used = 1'b1;
    set_fwd(0, 1'b1, 5'd0, 32'hFF, 1'b0);
    push(bc, RF1, RF2, 1'b0, "rs_zero");
    es_allow_in = 1'b1;
    step();
    idle_inputs();

    // An unused source does not stall even on a matching non-ready producer.
    load(bd);
    rs1_addr = 5'd6; rs1_used = 1'b0;
    set_fwd(0, 1'b1, 5'd6, 32'h66, 1'b0);
    push(bd, RF1, RF2, 1'b0, "rs_unused");
    es_allow_in = 1'b1;
    step();
    idle_inputs();

    // Branch cancel waits for EX, then drops the wrong-path fetch.
    load(bc);
    br_taken = 1'b1;
    @(negedge clk);
    check("br_blocked_cancel", BUS_W'(br_cancel), '0);
    check("br_blocked_allow_in", BUS_W'(ds_allow_in), '0);
    step();
    es_allow_in    = 1'b1;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = bd;
    push(bc, RF1, RF2, 1'b1, "br_cancel");
    step();
    fs_to_ds_valid = 1'b0;
    br_taken       = 1'b0;
    @(negedge clk);
    check("br_dropped_valid", BUS_W'(ds_to_es_valid), '0);
    check("br_dropped_allow_in", BUS_W'(ds_allow_in), BUS_W'(1));
    step();
    idle_inputs();

    // Flush kills the held instruction.
    load(be);
    flush = 1'b1;
    step();
    flush = 1'b0;
    es_allow_in = 1'b1;
    @(negedge clk);
    check("flush_valid", BUS_W'(ds_to_es_valid), '0);
    check("flush_allow_in", BUS_W'(ds_allow_in), BUS_W'(1));
    step();
    idle_inputs();

    // Reset in the middle of a stall.
    load(bf);
    rs2_addr = 5'd7; rs2_used = 1'b1;
    set_fwd(0, 1'b1, 5'd7, 32'h0, 1'b0);
    es_allow_in = 1'b1;
    @(negedge clk);
    check("pre_reset_stall", BUS_W'(ds_to_es_valid), '0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("midstall_reset_valid", BUS_W'(ds_to_es_valid), '0);
    check("midstall_reset_allow_in", BUS_W'(ds_allow_in), BUS_W'(1));
    check("midstall_reset_bus", ds_bus, '0);
    check("midstall_reset_stall_cnt", BUS_W'(stall_cnt), '0);
    step();

`ifdef ID_STALL_CNT_EN
    load(ba);
    rs1_addr = 5'd4; rs1_used = 1'b1;
    set_fwd(1, 1'b1, 5'd4, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    idle_inputs();
    @(negedge clk);
    check("stall_cnt_four", BUS_W'(stall_cnt), BUS_W'(4));
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("stall_cnt_after_flush", BUS_W'(stall_cnt), BUS_W'(4));
    step();
`endif

    check("scoreboard_drained", BUS_W'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
